// File: rtl/vector_list_player_pkg.sv
// Shared definitions for the vector display-list player: default widths,
// display-list entry field offsets and the playback state encoding.
package vector_list_player_pkg;

    localparam int COORD_W_DEFAULT = 12;
    localparam int ADDR_W_DEFAULT  = 8;

    // Entry layout, LSB first: x, y, jump, last.
    localparam int X_LSB = 0;

    function automatic int y_lsb(input int coord_w);
        return coord_w;
    endfunction

    function automatic int jump_bit(input int coord_w);
        return 2 * coord_w;
    endfunction

    function automatic int last_bit(input int coord_w);
        return 2 * coord_w + 1;
    endfunction

    function automatic int entry_w(input int coord_w);
        return 2 * coord_w + 2;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_ISSUE
    } state_e;

endpackage

// File: rtl/vector_list_ram.sv
// Simple dual-port display-list memory: one write port, one read port with a
// registered output. A same-address read and write returns the old contents.
module vector_list_ram
    import vector_list_player_pkg::*;
#(
    parameter int DATA_W = entry_w(COORD_W_DEFAULT),
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // No reset on the array or read register so the memory maps onto block RAM
    // and survives a player reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/vector_list_player.sv
// Walks a display list of beam targets and hands each one to a line drawer as
// a single-cycle draw strobe, optionally looping over the list forever.
module vector_list_player
    import vector_list_player_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [2*COORD_W+1:0] wr_data,
    input  logic                 start,
    input  logic                 loop_en,
    input  logic                 ready,
    output logic                 draw,
    output logic                 jump,
    output logic [COORD_W-1:0]   x,
    output logic [COORD_W-1:0]   y,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int ENTRY_W  = entry_w(COORD_W);
    localparam int Y_LSB    = y_lsb(COORD_W);
    localparam int JUMP_BIT = jump_bit(COORD_W);
    localparam int LAST_BIT = last_bit(COORD_W);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 last_q, last_d;
    logic                 draw_q, draw_d;
    logic                 draw_prev_q;
    logic                 jump_q, jump_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [ENTRY_W-1:0]   rd_data;

    vector_list_ram #(
        .DATA_W (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (state_q == ST_READ),
        .rd_addr_i (addr_q),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_d       = last_q;
        draw_d       = 1'b0;
        jump_d       = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The read register is not re-enabled in WAIT, so host writes
                // cannot disturb the entry being held here.
                last_d = rd_data[LAST_BIT];
                if (ready && !draw_prev_q) begin
                    draw_d  = 1'b1;
                    jump_d  = rd_data[JUMP_BIT];
                    x_d     = rd_data[Y_LSB-1:X_LSB];
                    y_d     = rd_data[JUMP_BIT-1:Y_LSB];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!last_q) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_READ;
                end else if (loop_en) begin
                    addr_d  = '0;
                    state_d = ST_READ;
                end else begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            last_q       <= 1'b0;
            draw_q       <= 1'b0;
            draw_prev_q  <= 1'b0;
            jump_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            draw_q       <= draw_d;
            draw_prev_q  <= draw_q;
            jump_q       <= jump_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign draw       = draw_q;
    assign jump       = jump_q;
    assign x          = x_q;
    assign y          = y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vector_list_player.sv
// Bench for vector_list_player: directed and randomized display lists checked
// against a pointer-walk model of the list held in a bench-side memory copy.
module tb_vector_list_player;

    localparam int CW    = 12;
    localparam int AW    = 8;
    localparam int EW    = 2 * CW + 2;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [EW-1:0] wr_data;
    logic          start;
    logic          loop_en;
    logic          ready;
    logic          draw;
    logic          jump;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          busy;
    logic          frame_done;

    vector_list_player #(.COORD_W(CW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .loop_en    (loop_en),
        .ready      (ready),
        .draw       (draw),
        .jump       (jump),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [EW-1:0] mem_m [DEPTH];
    int            m_ptr    = 0;
    bit            m_active = 1'b0;
    bit            fd_expect = 1'b0;
    int            draw_cnt = 0;
    int            cyc      = 0;
    int            last_draw_cyc = -1;
    bit            drawer_mode = 1'b0;
    logic [EW-1:0] exp_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [EW-1:0] mk(input bit last, input bit jmp, input int yv, input int xv);
        logic [CW-1:0] yy;
        logic [CW-1:0] xx;
        yy = CW'(yv);
        xx = CW'(xv);
        return {last, jmp, yy, xx};
    endfunction

    always @(posedge clk) cyc++;

    // Reference: a pointer walks the list; each draw must show the entry the
    // pointer names, and the pass ends or restarts on a last entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (fd_expect || frame_done) begin
                check("frame_done", 32'(frame_done), 32'(fd_expect));
                if (fd_expect) check("busy_after_frame", 32'(busy), 32'd0);
                fd_expect = 1'b0;
            end
            if (!draw && jump) check("jump_without_draw", 32'(jump), 32'd0);
            if (draw) begin
                check("draw_while_active", 32'(m_active), 32'd1);
                check("ready_at_draw", 32'(ready), 32'd1);
                if (last_draw_cyc >= 0)
                    check("draw_spacing", 32'(cyc - last_draw_cyc >= 3), 32'd1);
                last_draw_cyc = cyc;
                exp_e = mem_m[m_ptr];
                $display("draw #%0d addr=%0d x=%0d y=%0d jump=%0b", draw_cnt, m_ptr, x, y, jump);
                check("draw_x", 32'(x), 32'(exp_e[CW-1:0]));
                check("draw_y", 32'(y), 32'(exp_e[2*CW-1:CW]));
                check("draw_jump", 32'(jump), 32'(exp_e[2*CW]));
                draw_cnt++;
                if (!exp_e[2*CW+1]) begin
                    m_ptr = (m_ptr + 1) % DEPTH;
                end else if (loop_en) begin
                    m_ptr = 0;
                end else begin
                    m_active  = 1'b0;
                    fd_expect = 1'b1;
                end
            end
        end
    end

    // Line-drawer emulation: after each draw, stay busy for a random while.
    always @(posedge clk) begin
        int n;
        if (drawer_mode && draw && !reset) begin
            n = int'($urandom_range(0, 5));
            #2 ready = 1'b0;
            repeat (n) @(posedge clk);
            #2 ready = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input logic [EW-1:0] d);
        tick();
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        mem_m[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        if (!m_active) begin
            m_active = 1'b1;
            m_ptr    = 0;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_draw"}, 32'(draw), 32'd0);
        check({tag, "_jump"}, 32'(jump), 32'd0);
        check({tag, "_x"}, 32'(x), 32'd0);
        check({tag, "_y"}, 32'(y), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_outputs_zero(tag);
        m_active      = 1'b0;
        fd_expect     = 1'b0;
        last_draw_cyc = -1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_draws(input int n, input string tag);
        int k = 0;
        while (draw_cnt < n && k < n * 12 + 40) begin
            @(posedge clk);
            #3;
            k++;
        end
        check({tag, "_draw_timeout"}, 32'(draw_cnt >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while ((m_active || busy) && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        check({tag, "_idle_timeout"}, 32'(k < budget), 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        loop_en = 1'b0;
        ready   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        reset = 1'b0;

        // Square outline, one pass; a second start while busy is ignored.
        wr(0, mk(0, 0, 0, 0));
        wr(1, mk(0, 0, 0, 50));
        wr(2, mk(0, 0, 50, 50));
        wr(3, mk(1, 1, 50, 0));
        draw_cnt = 0;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_draws(1, "square");
        pulse_start();
        wait_idle(100, "square");
        check("square_draws", 32'(draw_cnt), 32'd4);
        check("square_x_held", 32'(x), 32'd0);
        check("square_y_held", 32'(y), 32'd50);
        check("square_busy", 32'(busy), 32'd0);

        // Looping playback, then drop loop_en to finish the current pass.
        tick();
        loop_en  = 1'b1;
        draw_cnt = 0;
        pulse_start();
        wait_draws(10, "loop");
        tick();
        loop_en = 1'b0;
        wait_idle(100, "loop");
        check("loop_whole_passes", 32'(draw_cnt % 4), 32'd0);
        check("loop_repeated", 32'(draw_cnt >= 12), 32'd1);

        // Drawer not ready for 20 cycles after start.
        tick();
        ready    = 1'b0;
        draw_cnt = 0;
        pulse_start();
        repeat (20) tick();
        check("no_draw_while_not_ready", 32'(draw_cnt), 32'd0);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("draw_after_ready", 32'(draw), 32'd1);
        wait_idle(100, "ready");

        // Reset between the 2nd and 3rd draw, then replay the intact list.
        draw_cnt = 0;
        pulse_start();
        wait_draws(2, "abort");
        do_reset("abort");
        draw_cnt = 0;
        pulse_start();
        wait_idle(100, "replay");
        check("replay_draws", 32'(draw_cnt), 32'd4);

        // Rewrite entries while the list is playing.
        for (int i = 0; i < 6; i++)
            wr(i, mk(i == 5, $urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))));
        tick();
        loop_en  = 1'b1;
        draw_cnt = 0;
        pulse_start();
        wait_draws(1, "rewrite");
        wr(3, mk(0, 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))));
        wait_draws(2, "rewrite");
        wr(0, mk(0, 0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))));
        wait_draws(14, "rewrite");
        tick();
        loop_en = 1'b0;
        wait_idle(100, "rewrite");
        check("rewrite_whole_passes", 32'(draw_cnt % 6), 32'd0);

        // Random lists against a drawer that stalls for random periods.
        drawer_mode = 1'b1;
        for (int t = 0; t < 3; t++) begin
            len = int'($urandom_range(3, 10));
            for (int i = 0; i < len; i++)
                wr(i, mk(i == len - 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))));
            draw_cnt = 0;
            pulse_start();
            wait_idle(200, "random");
            check("random_draws", 32'(draw_cnt), 32'(len));
        end
        drawer_mode = 1'b0;
        repeat (8) tick();
        ready = 1'b1;

        // No last flag anywhere: the address wraps past the top of the list.
        for (int i = 0; i < DEPTH; i++)
            wr(i, mk(0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))));
        draw_cnt = 0;
        pulse_start();
        wait_draws(DEPTH + 3, "wrap");
        do_reset("wrap_stop");
        check("wrap_draws", 32'(draw_cnt >= DEPTH + 3), 32'd1);

        // One-point list at address 0.
        wr(0, mk(1, 0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))));
        draw_cnt = 0;
        pulse_start();
        wait_idle(50, "single");
        check("single_draws", 32'(draw_cnt), 32'd1);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_list_player.md
VECTOR_LIST_PLAYER -- requirements
Module: vector_list_player

Interface
REQ-001 Parameter COORD_W, default 12, coordinate width in bits.
REQ-002 Parameter ADDR_W, default 8, display-list address width; depth = 2**ADDR_W entries.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  host write strobe into the display list.
REQ-006 wr_addr  input  ADDR_W  host write address.
REQ-007 wr_data  input  2*COORD_W+2  entry: {last, jump, y, x}; x in [COORD_W-1:0], y above it, then jump, with last as the MSB.
REQ-008 start  input  1  single-cycle pulse that begins playback at address 0.
REQ-009 loop_en  input  1  when high, playback restarts at address 0 after the last entry.
REQ-010 ready  input  1  line-drawer idle indication.
REQ-011 draw  output  1  single-cycle command strobe to the line drawer.
REQ-012 jump  output  1  high with draw: move beam blanked rather than drawing.
REQ-013 x  output  COORD_W  target X, valid in the draw cycle and held afterwards.
REQ-014 y  output  COORD_W  target Y, valid in the draw cycle and held afterwards.
REQ-015 busy  output  1  high from the start-acceptance cycle until playback ends.
REQ-016 frame_done  output  1  single-cycle pulse after the last entry of a non-looping pass is issued.

Function
REQ-017 The display list SHALL be a synchronous RAM with 1-cycle read latency; a write and a read to the same address in the same cycle SHALL return the old data.
REQ-018 The FSM SHALL have exactly the states IDLE, READ, WAIT, ISSUE.
REQ-019 In IDLE, start=1 SHALL clear the address to 0, set busy, and move to READ; start in any other state SHALL be ignored.
REQ-020 READ SHALL present the address to the RAM and go to WAIT the next cycle; WAIT SHALL latch the entry.
REQ-021 WAIT SHALL move to ISSUE only when ready=1 and draw was 0 in the previous cycle.
REQ-022 ISSUE SHALL assert draw for exactly one cycle, drive jump from the entry (for that cycle only), and load x and y from the entry.
REQ-023 After ISSUE: if last=0, increment the address and go to READ; if last=1 and loop_en=1, reset the address to 0 and go to READ; if last=1 and loop_en=0, pulse frame_done, clear busy, and go to IDLE.
REQ-024 The address SHALL wrap from 2**ADDR_W-1 to 0 when no entry has last set.
REQ-025 Successive draw pulses SHALL be separated by at least 3 cycles; draw SHALL never be asserted while ready=0.
REQ-026 loop_en SHALL be sampled only in the ISSUE cycle of a last entry.
REQ-027 An entry at address 0 with last=1 SHALL be issued once; it is a valid one-point list.
REQ-028 Host writes SHALL be accepted in every state; an entry already latched in WAIT is unaffected.

Reset
REQ-029 While reset is high: state=IDLE, address=0, draw=0, jump=0, x=0, y=0, busy=0, frame_done=0.
REQ-030 Reset asserted mid-playback SHALL abort playback immediately with no further draw; RAM contents SHALL be preserved.

Structure
REQ-031 The shared package SHALL hold COORD_W, ADDR_W defaults, the entry field offsets, and the FSM state enumeration.
REQ-032 The RAM SHALL be one sub-module, vector_list_ram (simple dual-port: one write port, one registered read port).

Verification
REQ-033 Load (0,0), (50,0), (50,50), and (0,50) with jump and last set; pulse start with loop_en=0 and ready tied high -> four draw pulses carrying those coordinates, jump only on the fourth, then one frame_done pulse and busy=0.
REQ-034 Same list with loop_en=1 -> draw sequence repeats from (0,0) with no frame_done; drop loop_en -> the pass in progress completes, then frame_done.
REQ-035 Hold ready low for 20 cycles after start -> no draw; draw occurs within 1 cycle after ready rises.
REQ-036 Pulse start again while busy -> no restart; the sequence is unchanged.
REQ-037 Assert reset between the 2nd and 3rd draw -> all outputs 0 immediately; after reset, start replays from (0,0) with the list intact.
REQ-038 Write a new value to address 3 during playback, before address 3 is read -> the new value is issued; write to address 0 during the same pass -> takes effect on the next loop.
